vec_acc: RTL and testbench

Per-element vector accumulator that terminates the product stream of the word-recognition datapath. It consumes signed product vectors beat by beat with valid/last/ready handshaking, sums each lane across all beats of a frame, and emits one accumulated vector per frame. The output is held until the downstream stage accepts it. It sits directly downstream of the vector multiplier and feeds the classifier/argmax stage.

---
 rtl/vec_acc_pkg.sv | 24 ++
 rtl/vec_acc_if.sv | 39 +++
 rtl/vec_acc_lane.sv | 49 ++++
 rtl/vec_acc.sv | 87 ++++++++
 tb/tb_vec_acc.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_acc_pkg.sv
// vec_acc_pkg
// Shared definitions for the vector accumulator and the argmax stage that
// follows it.
//   state_t        : FSM encoding, ACCUM = 1'b0, HOLD = 1'b1
//   sat_max(width) : largest value a signed width-bit lane can hold
//   sat_min(width) : smallest value a signed width-bit lane can hold
package vec_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Upper clamp bound for a signed lane of the given width.
  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  // Lower clamp bound for a signed lane of the given width.
  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/vec_acc_if.sv
// vec_acc_if
// Handshake bundle between the product stream, the accumulator and the
// classifier stage.
//   data_i  : packed signed input beat, lane i at [(i+1)*I_BW-1 : i*I_BW]
//   valid_i : input beat valid
//   last_i  : final beat of the frame, meaningful only on an accepted beat
//   ready_o : accumulator can take a beat
//   data_o  : packed signed accumulated vector, same lane packing at O_BW
//   valid_o : accumulated vector valid
//   ovf_o   : some lane overflowed during the frame, qualified by valid_o
//   ready_i : downstream takes the result
// modport slave is the accumulator side, master is the side driving beats
// and consuming results.
interface vec_acc_if #(
  parameter int I_BW       = 16,
  parameter int O_BW       = 24,
  parameter int VECTOR_LEN = 13
) ();

  logic [VECTOR_LEN*I_BW-1:0] data_i;
  logic                       valid_i;
  logic                       last_i;
  logic                       ready_o;
  logic [VECTOR_LEN*O_BW-1:0] data_o;
  logic                       valid_o;
  logic                       ovf_o;
  logic                       ready_i;

  modport slave (
    input  data_i, valid_i, last_i, ready_i,
    output ready_o, data_o, valid_o, ovf_o
  );

  modport master (
    output data_i, valid_i, last_i, ready_i,
    input  ready_o, data_o, valid_o, ovf_o
  );

endinterface

// File: rtl/vec_acc_lane.sv
// vec_acc_lane
// Next-value logic for one accumulator lane: sign-extend the incoming
// element, add it to the running sum (or to zero on the first beat of a
// frame), flag overflow and reduce back to O_BW bits.
// Build option: VEC_ACC_SATURATE_EN clamps an overflowing lane to the signed
// O_BW range; without it the lane wraps modulo 2^O_BW.
//   din   : signed input element, I_BW bits
//   acc   : current accumulator value, O_BW bits
//   first : this beat starts a new frame, ignore acc
//   nxt   : value to load into the accumulator
//   ovf   : the O_BW+1-bit sum does not fit in O_BW bits
module vec_acc_lane #(
  parameter int I_BW = 16,
  parameter int O_BW = 24
) (
  input  logic [I_BW-1:0] din,
  input  logic [O_BW-1:0] acc,
  input  logic            first,
  output logic [O_BW-1:0] nxt,
  output logic            ovf
);

`ifdef VEC_ACC_SATURATE_EN
  import vec_acc_pkg::*;
  localparam logic [O_BW-1:0] SAT_MAX = O_BW'(sat_max(O_BW));
  localparam logic [O_BW-1:0] SAT_MIN = O_BW'(sat_min(O_BW));
`endif

  logic [O_BW:0] din_ext;
  logic [O_BW:0] acc_ext;
  logic [O_BW:0] sum;

  // One guard bit above O_BW: the sum overflows exactly when the guard bit
  // disagrees with the O_BW sign bit. When saturating, the guard bit is the
  // true sign and picks which rail to clamp to.
  always_comb begin
    din_ext = {{(O_BW + 1 - I_BW){din[I_BW-1]}}, din};
    acc_ext = first ? '0 : {acc[O_BW-1], acc};
    sum     = acc_ext + din_ext;
    ovf     = sum[O_BW] ^ sum[O_BW-1];
    nxt     = sum[O_BW-1:0];
`ifdef VEC_ACC_SATURATE_EN
    if (ovf) begin
      nxt = sum[O_BW] ? SAT_MIN : SAT_MAX;
    end
`endif
  end

endmodule

// File: rtl/vec_acc.sv
// vec_acc
// Per-lane vector accumulator at the end of the product stream. Beats are
// summed lane by lane until the beat flagged last, then the total is held
// until the downstream stage takes it.
// Build option: VEC_ACC_SATURATE_EN selects clamping instead of wrap on lane
// overflow (see vec_acc_lane). ovf_o is reported the same way in both modes.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : vec_acc_if.slave handshake bundle (beats in, result out)
module vec_acc
  import vec_acc_pkg::*;
#(
  parameter int I_BW       = 16,
  parameter int O_BW       = 24,
  parameter int VECTOR_LEN = 13
) (
  input logic      clk_i,
  input logic      rst_n_i,
  vec_acc_if.slave bus
);

  state_t                     state;
  logic                       first;
  logic                       ovf;
  logic [VECTOR_LEN*O_BW-1:0] acc;
  logic [VECTOR_LEN*O_BW-1:0] acc_nxt;
  logic [VECTOR_LEN-1:0]      lane_ovf;
  logic                       accept;

  for (genvar gi = 0; gi < VECTOR_LEN; gi++) begin : g_lane
    vec_acc_lane #(
      .I_BW (I_BW),
      .O_BW (O_BW)
    ) u_lane (
      .din   (bus.data_i[gi*I_BW +: I_BW]),
      .acc   (acc[gi*O_BW +: O_BW]),
      .first (first),
      .nxt   (acc_nxt[gi*O_BW +: O_BW]),
      .ovf   (lane_ovf[gi])
    );
  end

  // Handshake outputs decode from the registered state only. ready_o is also
  // held low while reset is asserted so nothing upstream fires into a
  // block that is being cleared.
  assign bus.ready_o = (state == ACCUM) & rst_n_i;
  assign bus.valid_o = (state == HOLD);
  assign bus.data_o  = acc;
  assign bus.ovf_o   = ovf;

  assign accept = bus.valid_i & bus.ready_o;

  // Frame FSM. The accumulators load straight from the lane logic on every
  // accepted beat; the first flag makes the lanes reload instead of add and
  // also drops the previous frame's sticky overflow.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ACCUM;
      first <= 1'b1;
      ovf   <= 1'b0;
      acc   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc   <= acc_nxt;
            first <= 1'b0;
            ovf   <= (~first & ovf) | (|lane_ovf);
            if (bus.last_i) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.ready_i) begin
            state <= ACCUM;
            first <= 1'b1;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_acc.sv
// tb_vec_acc
// Self-checking bench for vec_acc. The main instance uses the default
// 16/24/13 configuration; a second 2-lane instance with O_BW = 16 exercises
// lane overflow. Expected results come from a behavioural lane model and are
// queued when the last beat of a frame is driven.
module tb_vec_acc;

  localparam int IW  = 16;
  localparam int OW  = 24;
  localparam int VL  = 13;
  localparam int DW  = VL * IW;
  localparam int QW  = VL * OW;
  localparam int VL2 = 2;
  localparam int OW2 = 16;

  typedef struct {
    logic [QW-1:0] data;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int fails  = 0;

  exp_t   sb[$];
  longint mdl[VL];
  bit     mdl_first = 1'b1;
  bit     mdl_ovf   = 1'b0;

  vec_acc_if #(.I_BW(IW), .O_BW(OW),  .VECTOR_LEN(VL))  acc_bus ();
  vec_acc_if #(.I_BW(IW), .O_BW(OW2), .VECTOR_LEN(VL2)) acc_bus16 ();

  vec_acc #(.I_BW(IW), .O_BW(OW), .VECTOR_LEN(VL)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (acc_bus.slave)
  );

  vec_acc #(.I_BW(IW), .O_BW(OW2), .VECTOR_LEN(VL2)) dut16 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (acc_bus16.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Behavioural lane update: exact integer sum, then clamp or wrap.
  function automatic longint mdl_add(input longint acc, input longint x, input bit first,
                                     input int ow, output bit ov);
    longint s, mx, mn;
    mx = (longint'(1) << (ow - 1)) - 1;
    mn = -(longint'(1) << (ow - 1));
    s  = (first ? longint'(0) : acc) + x;
    ov = (s > mx) || (s < mn);
    if (ov) begin
`ifdef VEC_ACC_SATURATE_EN
      s = (s > mx) ? mx : mn;
`else
      s = (s > mx) ? s - (longint'(1) << ow) : s + (longint'(1) << ow);
`endif
    end
    return s;
  endfunction

  task automatic model_beat(input logic [DW-1:0] d, input int lanes, input int ow);
    logic signed [IW-1:0] l;
    bit ov;
    bit any_ov;
    any_ov = 1'b0;
    for (int i = 0; i < lanes; i++) begin
      l = d[i*IW +: IW];
      mdl[i] = mdl_add(mdl[i], longint'(l), mdl_first, ow, ov);
      any_ov |= ov;
    end
    mdl_ovf   = (mdl_first ? 1'b0 : mdl_ovf) | any_ov;
    mdl_first = 1'b0;
  endtask

  task automatic model_push(input int lanes, input int ow);
    exp_t e;
    e.data = '0;
    for (int i = 0; i < lanes; i++) begin
      for (int b = 0; b < ow; b++) begin
        e.data[i*ow + b] = mdl[i][b];
      end
    end
    e.ovf = mdl_ovf;
    sb.push_back(e);
    mdl_first = 1'b1;
  endtask

  // Drive one beat on the main instance; it is taken at the next rising edge.
  task automatic beat(input logic [DW-1:0] d, input bit last);
    @(negedge clk);
    acc_bus.data_i  = d;
    acc_bus.valid_i = 1'b1;
    acc_bus.last_i  = last;
    model_beat(d, VL, OW);
    if (last) model_push(VL, OW);
    @(posedge clk);
  endtask

  task automatic beat16(input logic [VL2*IW-1:0] d, input bit last);
    @(negedge clk);
    acc_bus16.data_i  = d;
    acc_bus16.valid_i = 1'b1;
    acc_bus16.last_i  = last;
    model_beat(DW'(d), VL2, OW2);
    if (last) model_push(VL2, OW2);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      acc_bus.valid_i = 1'b0;
      acc_bus.last_i  = 1'($urandom_range(0, 1));
      acc_bus.data_i  = {7{$urandom}};
    end
  endtask

  // Stop driving and wait for valid_o; lat is the number of extra cycles
  // after the first sample point, or -1 if the budget runs out.
  task automatic wait_out(output int lat);
    @(negedge clk);
    acc_bus.valid_i = 1'b0;
    acc_bus.last_i  = 1'b0;
    lat = 0;
    while (!acc_bus.valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!acc_bus.valid_o) lat = -1;
  endtask

  task automatic wait_out16(output int lat);
    @(negedge clk);
    acc_bus16.valid_i = 1'b0;
    acc_bus16.last_i  = 1'b0;
    lat = 0;
    while (!acc_bus16.valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!acc_bus16.valid_o) lat = -1;
  endtask

  task automatic pop_expected(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    e.data = '0;
    e.ovf  = 1'b0;
    if (ok) e = sb.pop_front();
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (acc_bus.ready_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 0", acc_bus.ready_o); end
    checks++; if (acc_bus.valid_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", acc_bus.valid_o); end
    checks++; if (acc_bus.ovf_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_ovf: got %b expected 0", acc_bus.ovf_o); end
    checks++; if (acc_bus.data_o !== '0) begin fails++; $display("[TB] FAIL reset_data: got %h expected 0", acc_bus.data_o); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (acc_bus.ready_o !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_ready: got %b expected 1", acc_bus.ready_o); end
  endtask

  task automatic test_three_beat();
    logic [DW-1:0] d;
    exp_t e;
    bit ok;
    int lat;
    acc_bus.ready_i = 1'b1;
    d = '0; d[15:0] = 16'd5;    beat(d, 1'b0);
    d = '0; d[15:0] = 16'hFFFE; beat(d, 1'b0);
    d = '0; d[15:0] = 16'd7;    beat(d, 1'b1);
    wait_out(lat);
    pop_expected(e, ok);
    checks++; if (lat != 0) begin fails++; $display("[TB] FAIL three_beat_latency: got %0d expected 0", lat); end
    checks++; if (!ok || acc_bus.data_o !== e.data) begin fails++; $display("[TB] FAIL three_beat_data: got %h expected %h", acc_bus.data_o, e.data); end
    checks++; if (acc_bus.data_o[OW-1:0] !== 24'd10) begin fails++; $display("[TB] FAIL three_beat_lane0: got %0d expected 10", acc_bus.data_o[OW-1:0]); end
    checks++; if (acc_bus.ovf_o !== e.ovf) begin fails++; $display("[TB] FAIL three_beat_ovf: got %b expected %b", acc_bus.ovf_o, e.ovf); end
    checks++; if (acc_bus.ready_o !== 1'b0) begin fails++; $display("[TB] FAIL three_beat_ready_in_hold: got %b expected 0", acc_bus.ready_o); end
    @(negedge clk);
    checks++; if (acc_bus.valid_o !== 1'b0) begin fails++; $display("[TB] FAIL three_beat_one_cycle: got %b expected 0", acc_bus.valid_o); end
  endtask

  task automatic test_single_beat();
    logic [DW-1:0] d;
    exp_t e;
    bit ok;
    int lat;
    d = '1;
    beat(d, 1'b1);
    wait_out(lat);
    pop_expected(e, ok);
    checks++; if (!ok || acc_bus.data_o !== e.data) begin fails++; $display("[TB] FAIL single_neg1_data: got %h expected %h", acc_bus.data_o, e.data); end
    checks++; if (acc_bus.data_o[QW-1 -: OW] !== 24'hFFFFFF) begin fails++; $display("[TB] FAIL single_neg1_top_lane: got %h expected ffffff", acc_bus.data_o[QW-1 -: OW]); end
    @(negedge clk);
    d = '0; d[15:0] = 16'd3;
    beat(d, 1'b1);
    wait_out(lat);
    pop_expected(e, ok);
    checks++; if (!ok || acc_bus.data_o !== e.data) begin fails++; $display("[TB] FAIL single_reload_data: got %h expected %h", acc_bus.data_o, e.data); end
    @(negedge clk);
  endtask

  task automatic test_hold();
    logic [DW-1:0] d;
    exp_t e;
    bit ok;
    int lat;
    acc_bus.ready_i = 1'b0;
    d = '0; d[3*IW +: IW] = 16'd100; beat(d, 1'b0);
    d = '0; d[3*IW +: IW] = 16'd200; beat(d, 1'b1);
    wait_out(lat);
    pop_expected(e, ok);
    checks++; if (!ok || acc_bus.data_o !== e.data) begin fails++; $display("[TB] FAIL hold_data: got %h expected %h", acc_bus.data_o, e.data); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acc_bus.data_i  = '1;
      acc_bus.valid_i = 1'b1;
      acc_bus.last_i  = 1'b1;
      checks++; if (acc_bus.valid_o !== 1'b1) begin fails++; $display("[TB] FAIL hold_valid_c%0d: got %b expected 1", c, acc_bus.valid_o); end
      checks++; if (acc_bus.data_o !== e.data) begin fails++; $display("[TB] FAIL hold_stable_c%0d: got %h expected %h", c, acc_bus.data_o, e.data); end
      checks++; if (acc_bus.ready_o !== 1'b0) begin fails++; $display("[TB] FAIL hold_ready_c%0d: got %b expected 0", c, acc_bus.ready_o); end
    end
    @(negedge clk);
    acc_bus.valid_i = 1'b0;
    acc_bus.last_i  = 1'b0;
    acc_bus.ready_i = 1'b1;
    @(negedge clk);
    checks++; if (acc_bus.valid_o !== 1'b0) begin fails++; $display("[TB] FAIL hold_release_valid: got %b expected 0", acc_bus.valid_o); end
    checks++; if (acc_bus.ready_o !== 1'b1) begin fails++; $display("[TB] FAIL hold_release_ready: got %b expected 1", acc_bus.ready_o); end
    d = '0; d[15:0] = 16'd4;
    beat(d, 1'b1);
    wait_out(lat);
    pop_expected(e, ok);
    checks++; if (!ok || acc_bus.data_o !== e.data) begin fails++; $display("[TB] FAIL hold_next_frame: got %h expected %h", acc_bus.data_o, e.data); end
    @(negedge clk);
  endtask

  task automatic test_overflow16();
    exp_t e;
    bit ok;
    int lat;
    logic [OW2-1:0] rail;
`ifdef VEC_ACC_SATURATE_EN
    rail = 16'h7FFF;
`else
    rail = 16'h8000;
`endif
    acc_bus16.ready_i = 1'b1;
    beat16({16'h0000, 16'h7FFF}, 1'b0);
    beat16({16'h0000, 16'h0001}, 1'b1);
    wait_out16(lat);
    pop_expected(e, ok);
    checks++; if (!ok || acc_bus16.data_o !== e.data[VL2*OW2-1:0]) begin fails++; $display("[TB] FAIL ovf16_data: got %h expected %h", acc_bus16.data_o, e.data[VL2*OW2-1:0]); end
    checks++; if (acc_bus16.data_o[OW2-1:0] !== rail) begin fails++; $display("[TB] FAIL ovf16_lane0: got %h expected %h", acc_bus16.data_o[OW2-1:0], rail); end
    checks++; if (acc_bus16.ovf_o !== 1'b1) begin fails++; $display("[TB] FAIL ovf16_flag: got %b expected 1", acc_bus16.ovf_o); end
    @(negedge clk);
    beat16({16'h0000, 16'h0001}, 1'b0);
    beat16({16'h0000, 16'h0001}, 1'b1);
    wait_out16(lat);
    pop_expected(e, ok);
    checks++; if (!ok || acc_bus16.data_o !== e.data[VL2*OW2-1:0]) begin fails++; $display("[TB] FAIL ovf16_next_data: got %h expected %h", acc_bus16.data_o, e.data[VL2*OW2-1:0]); end
    checks++; if (acc_bus16.ovf_o !== e.ovf) begin fails++; $display("[TB] FAIL ovf16_next_flag: got %b expected %b", acc_bus16.ovf_o, e.ovf); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    exp_t e;
    bit ok;
    int lat;
    d = '0; d[15:0] = 16'd9;  beat(d, 1'b0);
    d = '0; d[15:0] = 16'd11; beat(d, 1'b0);
    @(negedge clk);
    acc_bus.valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (acc_bus.data_o !== '0) begin fails++; $display("[TB] FAIL midreset_data: got %h expected 0", acc_bus.data_o); end
    checks++; if (acc_bus.ready_o !== 1'b0) begin fails++; $display("[TB] FAIL midreset_ready: got %b expected 0", acc_bus.ready_o); end
    checks++; if (acc_bus.valid_o !== 1'b0) begin fails++; $display("[TB] FAIL midreset_valid: got %b expected 0", acc_bus.valid_o); end
    @(negedge clk);
    rst_n = 1'b1;
    mdl_first = 1'b1;
    d = '0; d[15:0] = 16'd4;
    beat(d, 1'b1);
    wait_out(lat);
    pop_expected(e, ok);
    checks++; if (!ok || acc_bus.data_o !== e.data) begin fails++; $display("[TB] FAIL midreset_next_frame: got %h expected %h", acc_bus.data_o, e.data); end
    @(negedge clk);
  endtask

  task automatic test_random_gaps();
    logic [DW-1:0] d;
    exp_t e;
    bit ok;
    int lat;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 8; b++) begin
        for (int i = 0; i < VL; i++) d[i*IW +: IW] = 16'($urandom);
        beat(d, b == 7);
        if (b != 7) idle($urandom_range(0, 3));
      end
      wait_out(lat);
      pop_expected(e, ok);
      checks++; if (lat != 0) begin fails++; $display("[TB] FAIL random_f%0d_latency: got %0d expected 0", f, lat); end
      checks++; if (!ok || acc_bus.data_o !== e.data) begin fails++; $display("[TB] FAIL random_f%0d_data: got %h expected %h", f, acc_bus.data_o, e.data); end
      checks++; if (acc_bus.ovf_o !== e.ovf) begin fails++; $display("[TB] FAIL random_f%0d_ovf: got %b expected %b", f, acc_bus.ovf_o, e.ovf); end
      @(negedge clk);
    end
  endtask

  initial begin
    acc_bus.data_i    = '0;
    acc_bus.valid_i   = 1'b0;
    acc_bus.last_i    = 1'b0;
    acc_bus.ready_i   = 1'b0;
    acc_bus16.data_i  = '0;
    acc_bus16.valid_i = 1'b0;
    acc_bus16.last_i  = 1'b0;
    acc_bus16.ready_i = 1'b0;
    for (int i = 0; i < VL; i++) mdl[i] = 0;
    $display("[TB] starting vec_acc bench");
    test_reset();
    test_three_beat();
    test_single_beat();
    test_hold();
    test_overflow16();
    test_reset_mid();
    test_random_gaps();
    checks++; if (sb.size() != 0) begin fails++; $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
